// File: rtl/avs_button_led_pio.sv
// avs_button_led_pio: Avalon-MM LED register plus debounced button/switch
// input port with rising-edge capture and a masked level interrupt.
//
// Ports:
//   clk, rstN          system clock, synchronous active-low reset
//   avs_address        word address (0 LED, 1 IN, 2 EDGE, 3 MASK)
//   avs_read/write     strobes; reads answer one cycle later, no stalls
//   avs_writedata      write data
//   avs_readdata       read data, qualified by avs_readdatavalid
//   avs_readdatavalid  one-cycle read-data qualifier
//   pio_out            LED register value
//   pio_in             raw asynchronous inputs
//   irq                registered level interrupt
module avs_button_led_pio #(
  parameter int OUT_WIDTH      = 8,
  parameter int IN_WIDTH       = 8,
  parameter int DEBOUNCE_COUNT = 500000
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [1:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 avs_readdatavalid,
  output logic [OUT_WIDTH-1:0] pio_out,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic                 irq
);

  localparam int CW = $clog2(DEBOUNCE_COUNT);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_COUNT - 1);

  logic [IN_WIDTH-1:0]  sync1;
  logic [IN_WIDTH-1:0]  sync2;
  logic [IN_WIDTH-1:0]  deb;
  logic [IN_WIDTH-1:0]  deb_nxt;
  logic [IN_WIDTH-1:0]  rise;
  logic [IN_WIDTH-1:0]  edge_r;
  logic [IN_WIDTH-1:0]  edge_nxt;
  logic [IN_WIDTH-1:0]  edge_clr;
  logic [IN_WIDTH-1:0]  mask_r;
  logic [OUT_WIDTH-1:0] led;
  logic [CW-1:0]        cnt     [IN_WIDTH];
  logic [CW-1:0]        cnt_nxt [IN_WIDTH];
  logic [31:0]          rd_mux;
  logic                 wr_led;
  logic                 wr_edge;
  logic                 wr_mask;
  logic                 unused_wdata;

  assign unused_wdata = ^avs_writedata;

  assign wr_led  = avs_write && (avs_address == 2'd0);
  assign wr_edge = avs_write && (avs_address == 2'd2);
  assign wr_mask = avs_write && (avs_address == 2'd3);

  // Counter runs only while the synced input disagrees with the
  // accepted value; any agreement restarts it, so short glitches die.
  always_comb begin
    deb_nxt = deb;
    cnt_nxt = cnt;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (sync2[i] == deb[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == TERM) begin
        deb_nxt[i] = sync2[i];
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  assign rise = deb_nxt & ~deb;

  // Set beats clear when both hit one bit in the same cycle.
  assign edge_clr = wr_edge ? avs_writedata[IN_WIDTH-1:0] : '0;
  assign edge_nxt = (edge_r & ~edge_clr) | rise;

  always_comb begin
    rd_mux = '0;
    unique case (avs_address)
      2'd0: rd_mux[OUT_WIDTH-1:0] = led;
      2'd1: rd_mux[IN_WIDTH-1:0]  = deb;
      2'd2: rd_mux[IN_WIDTH-1:0]  = edge_r;
      2'd3: rd_mux[IN_WIDTH-1:0]  = mask_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < IN_WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      sync1 <= pio_in;
      sync2 <= sync1;
      deb   <= deb_nxt;
      for (int i = 0; i < IN_WIDTH; i++)
        cnt[i] <= cnt_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      led               <= '0;
      edge_r            <= '0;
      mask_r            <= '0;
      irq               <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      if (wr_led)
        led <= avs_writedata[OUT_WIDTH-1:0];
      if (wr_mask)
        mask_r <= avs_writedata[IN_WIDTH-1:0];
      edge_r            <= edge_nxt;
      irq               <= |(edge_r & mask_r);
      avs_readdata      <= avs_read ? rd_mux : '0;
      avs_readdatavalid <= avs_read;
    end
  end

  assign pio_out = led;

endmodule

// File: tb/tb_avs_button_led_pio.sv
// tb_avs_button_led_pio: randomized and directed stimulus against a
// sample-history reference model, with a queue-based read scoreboard.
module tb_avs_button_led_pio;

  localparam int N = 4;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [W-1:0] pio_out;
  logic [W-1:0] pio_in = '0;
  logic        irq;

  avs_button_led_pio #(
    .OUT_WIDTH(W),
    .IN_WIDTH(W),
    .DEBOUNCE_COUNT(N)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .pio_out(pio_out),
    .pio_in(pio_in),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: pin samples per edge (h[0] newest), accepted value,
  // and the four registers as seen after the latest edge.
  bit [W-1:0] h [0:N+1];
  bit [W-1:0] m_led, m_mask, m_edge, m_deb;
  bit         m_irq, m_valid, started;
  logic [31:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit [W-1:0] nd, clr, rise;
    bit [31:0]  rv;
    bit         n_irq, same;
    if (!rstN) begin
      for (int k = 0; k <= N + 1; k++) h[k] = '0;
      m_led = '0; m_mask = '0; m_edge = '0; m_deb = '0;
      m_irq = 0; m_valid = 0; started = 1;
      exp_q.delete();
    end else begin
      if (avs_read) begin
        case (avs_address)
          2'd0: rv = 32'(m_led);
          2'd1: rv = 32'(m_deb);
          2'd2: rv = 32'(m_edge);
          default: rv = 32'(m_mask);
        endcase
        exp_q.push_back(rv);
      end
      m_valid = avs_read;
      n_irq = |(m_edge & m_mask);
      for (int k = N + 1; k > 0; k--) h[k] = h[k-1];
      h[0] = pio_in;
      // A bit is accepted once N consecutive synchronized samples
      // (ages 2..N+1 edges) all agree on a new value.
      nd = m_deb;
      for (int b = 0; b < W; b++) begin
        same = 1;
        for (int k = 3; k <= N + 1; k++)
          if (h[k][b] != h[2][b]) same = 0;
        if (same) nd[b] = h[2][b];
      end
      rise = nd & ~m_deb;
      clr = '0;
      if (avs_write) begin
        case (avs_address)
          2'd0: m_led = avs_writedata[W-1:0];
          2'd2: clr = avs_writedata[W-1:0];
          2'd3: m_mask = avs_writedata[W-1:0];
          default: ;
        endcase
      end
      m_edge = (m_edge & ~clr) | rise;
      m_deb = nd;
      m_irq = n_irq;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rdvalid", 32'(avs_readdatavalid), 32'(m_valid));
      if (avs_readdatavalid) begin
        if (exp_q.size() == 0)
          chk("rd_unexpected", 32'(avs_readdatavalid), 32'd0);
        else
          chk("readdata", avs_readdata, exp_q.pop_front());
      end else begin
        chk("rd_idle", avs_readdata, 32'd0);
      end
      chk("pio_out", 32'(pio_out), 32'(m_led));
      chk("irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic op(input bit rd, input bit wr, input logic [1:0] a,
                    input logic [31:0] d);
    avs_read = rd;
    avs_write = wr;
    avs_address = a;
    avs_writedata = d;
    @(negedge clk);
    avs_read = 0;
    avs_write = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a);
    op(1, 0, a, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    op(0, 1, a, d);
  endtask

  initial begin
    @(negedge clk);
    rstN = 0;
    idle(3);
    rstN = 1;
    for (int a = 0; a < 4; a++) rd(2'(a));
    idle(1);

    wr(0, 32'hA5);
    rd(0);
    idle(2);

    pio_in = 8'h01;
    idle(8);
    rd(1);
    rd(2);
    pio_in = 8'h03;
    idle(3);
    pio_in = 8'h01;
    idle(8);
    rd(1);
    rd(2);

    wr(2, 32'hFF);
    wr(3, 32'h01);
    pio_in = 8'h00;
    idle(8);
    pio_in = 8'h01;
    idle(10);
    rd(2);
    wr(2, 32'h01);
    idle(2);
    rd(2);

    pio_in = 8'h00;
    idle(8);
    pio_in = 8'h01;
    idle(5);
    wr(2, 32'h01);
    rd(2);
    idle(2);

    wr(0, 32'h11);
    op(1, 1, 2'd0, 32'h22);
    rd(0);
    idle(2);

    pio_in = 8'h04;
    idle(3);
    rstN = 0;
    idle(2);
    rstN = 1;
    rd(1);
    idle(5);
    rd(1);
    rd(2);
    idle(2);

    wr(3, 32'hFF);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0)
        pio_in[$urandom_range(0, W-1)] ^= 1'b1;
      if ($urandom_range(0, 799) == 0) begin
        rstN = 0;
        idle($urandom_range(1, 3));
        rstN = 1;
      end
      case ($urandom_range(0, 3))
        0: op(1, 0, 2'($urandom_range(0, 3)), 32'd0);
        1: op(0, 1, 2'($urandom_range(0, 3)), $urandom);
        2: op(1, 1, 2'($urandom_range(0, 3)), $urandom);
        default: idle(1);
      endcase
    end
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
